step_dir_decoder: RTL and testbench



---
 rtl/step_dir_pkg.sv | 18 +
 rtl/sync_glitch_filter.sv | 52 +++++
 rtl/step_dir_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_step_dir_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/step_dir_pkg.sv
// Shared constants and FSM encoding for the step/direction receive decoder.
package step_dir_pkg;

    localparam int FILT_CYCLES_DEF    = 4;
    localparam int DIR_SETUP_DEF      = 8;
    localparam int POS_W_DEF          = 32;
    localparam int PER_W_DEF          = 24;
    localparam int TIMEOUT_CYCLES_DEF = 200000;

    // Filter stability counter is sized for the full 1..255 range.
    localparam int FILT_CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sync_glitch_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only follows
// the input after FILT_CYCLES consecutive cycles of disagreement.
module sync_glitch_filter
    import step_dir_pkg::*;
#(
    parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [FILT_CNT_W-1:0] FILT_L  = FILT_CNT_W'(FILT_CYCLES);
    localparam logic [FILT_CNT_W-1:0] CNT_ONE = FILT_CNT_W'(1);

    logic                  sync1_r;
    logic                  sync2_r;
    logic                  filt_r;
    logic [FILT_CNT_W-1:0] cnt_r;

    // Metastability guard for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter; any agreeing cycle restarts the qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            filt_r <= 1'b0;
        end else if (sync2_r != filt_r) begin
            if ((cnt_r + CNT_ONE) == FILT_L) begin
                filt_r <= sync2_r;
                cnt_r  <= '0;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign dout = filt_r;

endmodule

// File: rtl/step_dir_decoder.sv
// Receive side of a PUL/DIR stepper link: filters both lines, counts steps into
// a signed position, measures step period and flags direction setup violations.
module step_dir_decoder
    import step_dir_pkg::*;
#(
    parameter int FILT_CYCLES    = FILT_CYCLES_DEF,
    parameter int DIR_SETUP      = DIR_SETUP_DEF,
    parameter int POS_W          = POS_W_DEF,
    parameter int PER_W          = PER_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pul_in,
    input  logic             dir_in,
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic             step_valid,
    output logic             step_dir,
    output logic [POS_W-1:0] position,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             moving,
    output logic             dir_err
);

    localparam int                 SETUP_W   = $clog2(DIR_SETUP + 1);
    localparam logic [SETUP_W-1:0] SETUP_L   = SETUP_W'(DIR_SETUP);
    localparam logic [SETUP_W-1:0] SETUP_ONE = SETUP_W'(1);
    localparam logic [PER_W-1:0]   PER_ONE   = PER_W'(1);
    localparam logic [PER_W-1:0]   PER_MAX   = {PER_W{1'b1}};
    localparam logic [PER_W-1:0]   TIMEOUT_L = PER_W'(TIMEOUT_CYCLES);
    localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);

    logic               pul_f_s;
    logic               dir_f_s;
    logic               pul_f_d_r;
    logic               dir_f_d_r;
    logic               step_s;
    logic               setup_viol_s;
    logic [SETUP_W-1:0] setup_cnt_r;
    logic               step_valid_r;
    logic               step_dir_r;
    logic [POS_W-1:0]   position_r;
    logic [PER_W-1:0]   period_cnt_r;
    logic [PER_W-1:0]   period_r;
    logic               period_valid_r;
    logic               dir_err_r;
    state_t             state_r;
    state_t             next_state_s;

    sync_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_pul_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pul_in),
        .dout  (pul_f_s)
    );

    sync_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_dir_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dir_in),
        .dout  (dir_f_s)
    );

    assign step_s = pul_f_s & ~pul_f_d_r;
    // A DIR change in the very step cycle counts as zero setup time.
    assign setup_viol_s = (dir_f_s != dir_f_d_r) || (setup_cnt_r < SETUP_L);

    // Previous filtered levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pul_f_d_r <= 1'b0;
            dir_f_d_r <= 1'b0;
        end else begin
            pul_f_d_r <= pul_f_s;
            dir_f_d_r <= dir_f_s;
        end
    end

    // Step strobe and the direction captured with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_valid_r <= 1'b0;
            step_dir_r   <= 1'b0;
        end else begin
            step_valid_r <= step_s;
            if (step_s) begin
                step_dir_r <= dir_f_s;
            end else begin
                step_dir_r <= step_dir_r;
            end
        end
    end

    // Position follows the registered step so a coincident clear always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position_r <= '0;
        end else if (pos_clr) begin
            position_r <= '0;
        end else if (step_valid_r) begin
            position_r <= step_dir_r ? (position_r - POS_ONE) : (position_r + POS_ONE);
        end else begin
            position_r <= position_r;
        end
    end

    // Cycles since the last filtered DIR change, saturating at the setup limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_cnt_r <= '0;
        end else if (dir_f_s != dir_f_d_r) begin
            setup_cnt_r <= '0;
        end else if (setup_cnt_r != SETUP_L) begin
            setup_cnt_r <= setup_cnt_r + SETUP_ONE;
        end else begin
            setup_cnt_r <= setup_cnt_r;
        end
    end

    // Sticky setup violation flag; a new violation beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_err_r <= 1'b0;
        end else if (step_s && setup_viol_s) begin
            dir_err_r <= 1'b1;
        end else if (err_clr) begin
            dir_err_r <= 1'b0;
        end else begin
            dir_err_r <= dir_err_r;
        end
    end

    // Free-running period counter restarted by each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_r <= '0;
        end else if (step_s) begin
            period_cnt_r <= PER_ONE;
        end else if (period_cnt_r != PER_MAX) begin
            period_cnt_r <= period_cnt_r + PER_ONE;
        end else begin
            period_cnt_r <= period_cnt_r;
        end
    end

    // Period capture only while already moving; the first step has no reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r       <= '0;
            period_valid_r <= 1'b0;
        end else if (step_s && (state_r == ST_RUN)) begin
            period_r       <= period_cnt_r;
            period_valid_r <= 1'b1;
        end else begin
            period_r       <= period_r;
            period_valid_r <= 1'b0;
        end
    end

    // Motion state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Motion next-state: a step always keeps or enters RUN, idle time ends it.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (step_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (step_s) begin
                    next_state_s = ST_RUN;
                end else if (period_cnt_r == TIMEOUT_L) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign step_valid   = step_valid_r;
    assign step_dir     = step_dir_r;
    assign position     = position_r;
    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign moving       = (state_r == ST_RUN);
    assign dir_err      = dir_err_r;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder; short timeout and 8-bit position keep
// the idle and wrap scenarios within a few thousand cycles.
module tb_step_dir_decoder;

    localparam int POS_W   = 8;
    localparam int PER_W   = 24;
    localparam int TIMEOUT = 500;

    logic             clk;
    logic             rst_n;
    logic             pul_in;
    logic             dir_in;
    logic             pos_clr;
    logic             err_clr;
    logic             step_valid;
    logic             step_dir;
    logic [POS_W-1:0] position;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             moving;
    logic             dir_err;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int sv_cnt  = 0;
    int pv_cnt  = 0;
    int sv0;
    int pv0;
    int at;

    step_dir_decoder #(
        .FILT_CYCLES    (4),
        .DIR_SETUP      (8),
        .POS_W          (POS_W),
        .PER_W          (PER_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pul_in       (pul_in),
        .dir_in       (dir_in),
        .pos_clr      (pos_clr),
        .err_clr      (err_clr),
        .step_valid   (step_valid),
        .step_dir     (step_dir),
        .position     (position),
        .period       (period),
        .period_valid (period_valid),
        .moving       (moving),
        .dir_err      (dir_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled on the quiet edge.
    always @(negedge clk) begin
        if (rst_n && step_valid)   sv_cnt <= sv_cnt + 1;
        if (rst_n && period_valid) pv_cnt <= pv_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pul_in pulse; report the cycle index at which step_valid was first seen.
    task automatic pulse(input int hi, input int lo, output int sv_at);
        sv_at  = -1;
        pul_in = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            @(negedge clk);
            if (step_valid && sv_at < 0) sv_at = i;
        end
        pul_in = 1'b0;
        for (int i = 1; i <= lo; i++) begin
            @(negedge clk);
            if (step_valid && sv_at < 0) sv_at = hi + i;
        end
    endtask

    initial begin
        pul_in = 1'b0; dir_in = 1'b0; pos_clr = 1'b0; err_clr = 1'b0; rst_n = 1'b0;
        tick(3);
        chk("rst_position", 64'(position), 64'd0);
        chk("rst_step_valid", 64'(step_valid), 64'd0);
        chk("rst_moving", 64'(moving), 64'd0);
        chk("rst_period", 64'(period), 64'd0);
        chk("rst_period_valid", 64'(period_valid), 64'd0);
        chk("rst_dir_err", 64'(dir_err), 64'd0);
        chk("rst_step_dir", 64'(step_dir), 64'd0);
        rst_n = 1'b1;
        tick(20);

        // Five forward pulses, 100-cycle spacing
        for (int k = 0; k < 5; k++) begin
            pulse(50, 50, at);
            chk("fwd_latency", 64'(at), 64'd7);
        end
        chk("fwd_steps", 64'(sv_cnt), 64'd5);
        chk("fwd_periods", 64'(pv_cnt), 64'd4);
        chk("fwd_position", 64'(position), 64'd5);
        chk("fwd_period", 64'(period), 64'd100);
        chk("fwd_moving", 64'(moving), 64'd1);
        chk("fwd_step_dir", 64'(step_dir), 64'd0);

        // Reverse with ample setup time
        dir_in = 1'b1;
        tick(100);
        sv0 = sv_cnt; pv0 = pv_cnt;
        for (int k = 0; k < 3; k++) pulse(50, 50, at);
        chk("rev_position", 64'(position), 64'd2);
        chk("rev_step_dir", 64'(step_dir), 64'd1);
        chk("rev_dir_err", 64'(dir_err), 64'd0);
        chk("rev_steps", 64'(sv_cnt - sv0), 64'd3);
        chk("rev_periods", 64'(pv_cnt - pv0), 64'd3);
        chk("rev_period", 64'(period), 64'd100);

        // Glitches shorter than the filter window are rejected
        sv0 = sv_cnt;
        pulse(1, 60, at);
        pulse(2, 60, at);
        pulse(3, 60, at);
        chk("glitch_no_step", 64'(sv_cnt - sv0), 64'd0);
        chk("glitch_last_at", 64'(at), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("glitch_position", 64'(position), 64'd2);
        pulse(4, 96, at);
        chk("min_pulse_at", 64'(at), 64'd7);
        chk("min_pulse_steps", 64'(sv_cnt - sv0), 64'd1);
        chk("min_pulse_position", 64'(position), 64'd1);

        // DIR change 5 cycles before the step violates setup
        dir_in = 1'b0;
        tick(5);
        sv0 = sv_cnt;
        pulse(50, 50, at);
        chk("setup_dir_err", 64'(dir_err), 64'd1);
        chk("setup_steps", 64'(sv_cnt - sv0), 64'd1);
        chk("setup_position", 64'(position), 64'd2);
        chk("setup_step_dir", 64'(step_dir), 64'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", 64'(dir_err), 64'd0);

        // Idle timeout: moving drops exactly TIMEOUT cycles after the last step_valid
        tick(TIMEOUT - 95);
        chk("timeout_before", 64'(moving), 64'd1);
        chk("timeout_period", 64'(period), 64'd105);
        tick(1);
        chk("timeout_at", 64'(moving), 64'd0);
        chk("timeout_period_hold", 64'(period), 64'd105);
        sv0 = sv_cnt; pv0 = pv_cnt;
        pulse(50, 50, at);
        chk("restart_moving", 64'(moving), 64'd1);
        chk("restart_no_period", 64'(pv_cnt - pv0), 64'd0);
        chk("restart_steps", 64'(sv_cnt - sv0), 64'd1);
        chk("restart_position", 64'(position), 64'd3);

        // Clear coincident with step_valid
        pul_in = 1'b1;
        tick(7);
        chk("clr_step_valid", 64'(step_valid), 64'd1);
        pos_clr = 1'b1;
        tick(1);
        pos_clr = 1'b0;
        chk("clr_position", 64'(position), 64'd0);
        pul_in = 1'b0;
        tick(60);
        chk("clr_position_hold", 64'(position), 64'd0);

        // Wrap from max positive to min negative
        for (int k = 0; k < 127; k++) pulse(5, 5, at);
        chk("wrap_max", 64'(position), 64'h7F);
        pulse(5, 5, at);
        chk("wrap_min", 64'(position), 64'h80);
        chk("fast_period", 64'(period), 64'd10);

        // Asynchronous reset in the middle of a pulse
        sv0 = sv_cnt;
        pul_in = 1'b1;
        tick(10);
        chk("pre_rst_moving", 64'(moving), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_position", 64'(position), 64'd0);
        chk("mid_rst_moving", 64'(moving), 64'd0);
        chk("mid_rst_period", 64'(period), 64'd0);
        pul_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("post_rst_position", 64'(position), 64'd0);
        chk("post_rst_steps", 64'(sv_cnt - sv0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
